d2l_tx_scheduler: RTL and testbench
===================================

// Module: d2l_tx_scheduler
// PURPOSE
//  Shares the single dual-line serial master between NREQ requesters using round-robin arbitration.
//  Captures the winner's {len, payload} into the master's 71-bit data word and pulses out_en.
//  Tracks the transfer through the master's CS, then returns per-requester done/error.
//  Sits between client logic and the master; it is the only driver of master data/out_en.
// PARAMETERS
//  NREQ      4    number of requesters (2..8)
//  EN_CYC    2    clk cycles m_out_en is held high per launch (1..15)
//  GAP_CYC   4    min idle clk cycles between CS rise and next launch (0..255)
//  TO_CYC    1024 timeout for each of CS-fall and CS-rise waits (16..65535)
// PORTS
//  clk       in   1          system clock
//  rstn      in   1          asynchronous active-low reset
//  req       in   NREQ       per-requester request, level; held until its ack
//  req_len   in   7*NREQ     per-requester bit count, slice i = [7i+6:7i]
//  req_data  in   64*NREQ    per-requester payload, LSB-aligned, slice i = [64i+63:64i]
//  ack       out  NREQ       one-hot 1-cycle pulse: request captured
//  done      out  NREQ       one-hot 1-cycle pulse: transfer finished (CS returned high)
//  err       out  NREQ       one-hot 1-cycle pulse: rejected length or timeout
//  busy      out  1          high from grant until return to IDLE
//  m_data    out  71         to master data: {len[6:0], payload[63:0]}
//  m_out_en  out  1          to master out_en
//  m_cs      in   1          from master CS; high = idle, low = transfer active
// BEHAVIOUR
//  Reset (async, rstn low): state=IDLE, ack/done/err/busy/m_out_en=0, m_data=0, rr pointer=0,
//   counters=0. Reset mid-transfer abandons it silently; no done/err issued.
//  States: IDLE -> CHECK -> LAUNCH -> WAIT_LO -> WAIT_HI -> GAP -> IDLE.
//  IDLE: if any req and m_cs==1, pick first set bit searching from ptr upward (wrap at NREQ);
//   latch index, len and payload; ack[idx]=1 next cycle; go CHECK. If m_cs==0, stay IDLE.
//  CHECK (1 cycle): len valid iff 2<=len<=64 and len even. Invalid -> err[idx] pulse,
//   ptr=idx+1 mod NREQ, -> IDLE (no launch, no GAP). Valid -> m_data={len,payload}, -> LAUNCH.
//  LAUNCH: m_out_en=1 for exactly EN_CYC cycles, m_data held; then m_out_en=0 -> WAIT_LO.
//  WAIT_LO: wait m_cs==0 (sampled). Counter starts at entry; TO_CYC cycles without fall ->
//   err[idx], -> GAP. CS may fall during LAUNCH; that is accepted (skip straight past WAIT_LO).
//  WAIT_HI: wait m_cs==1; on rise done[idx] pulse, -> GAP. TO_CYC cycles without rise ->
//   err[idx], -> GAP.
//  GAP: count GAP_CYC cycles (0 = pass through in 1 cycle), ptr=idx+1 mod NREQ, -> IDLE.
//  m_data held stable from CHECK exit until GAP exit; cleared to 0 on return to IDLE.
//  busy=1 in CHECK..GAP, 0 in IDLE. done and err never pulse together.
//  req dropped after ack has no effect on the in-flight transfer.
//  Simultaneous requests: winner by rr order only; losers keep req high, no ack.
//  Earliest launch: grant cycle +1 (ack), CHECK +1, m_out_en high at cycle 2 after req seen.
//  Width rules: req_len used as 7-bit unsigned; payload passed unmodified, no shifting.
// TESTING
//  1 Single req0 len=8 data=0x5A, master model drops CS 3 clk after out_en, raises 40 clk
//    later -> ack[0] @+1, m_out_en 2 cycles, m_data={7'd8,56'd0,8'h5A}, done[0] once.
//  2 req=4'b1111 all len=16 held continuously -> grants in order 0,1,2,3,0; each done before
//    next ack; spacing from CS rise to next m_out_en >= GAP_CYC+2 clk.
//  3 req1 len=7, then len=0, then len=66 -> err[1] each, m_out_en never asserted, ptr -> 2.
//  4 Master model never lowers CS -> err[idx] exactly TO_CYC clk after WAIT_LO entry, busy
//    falls after GAP; same with CS stuck low -> err after TO_CYC in WAIT_HI, no done.
//  5 rstn low mid WAIT_HI with len=64 data=0xFEDC_BA98_7654_3210 -> all outputs 0
//    asynchronously, no done/err; after release, held req re-arbitrated from ptr=0.
//  6 req asserted while m_cs==0 (external) -> no ack until CS high; then normal launch.

Source files
------------

// File: rtl/d2l_tx_scheduler.sv
// ---------------------------------------------------------------------------
// d2l_tx_scheduler
//
// Shares one dual-line serial master between NREQ requesters using
// round-robin arbitration. The winner's {len, payload} is captured into the
// master's 71-bit data word and out_en is pulsed. The transfer is then
// tracked through the master's CS line. Each requester gets a one-cycle
// done or err pulse at the end. This block is the only driver of the
// master's data and out_en.
//
// Parameters
//   NREQ     number of requesters (2..8)
//   EN_CYC   cycles m_out_en_o is held high per launch (1..15)
//   GAP_CYC  idle cycles spent after a transfer before re-arbitrating (0..255)
//   TO_CYC   timeout for each of the CS-fall and CS-rise waits (16..65535)
//
// Ports
//   clk_i        system clock
//   rstn_i       asynchronous active-low reset
//   req_i        per-requester request level, held until its ack
//   req_len_i    per-requester bit count, slice i = [7i+6:7i]
//   req_data_i   per-requester payload, slice i = [64i+63:64i]
//   ack_o        one-hot pulse: request captured
//   done_o       one-hot pulse: transfer finished (CS returned high)
//   err_o        one-hot pulse: rejected length or timeout
//   busy_o       high from grant until return to IDLE
//   m_data_o     to master data: {len[6:0], payload[63:0]}
//   m_out_en_o   to master out_en
//   m_cs_i       from master CS, high = idle, low = transfer active
// ---------------------------------------------------------------------------
module d2l_tx_scheduler #(
    parameter int NREQ    = 4,
    parameter int EN_CYC  = 2,
    parameter int GAP_CYC = 4,
    parameter int TO_CYC  = 1024
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [NREQ-1:0]    req_i,
    input  logic [7*NREQ-1:0]  req_len_i,
    input  logic [64*NREQ-1:0] req_data_i,
    output logic [NREQ-1:0]    ack_o,
    output logic [NREQ-1:0]    done_o,
    output logic [NREQ-1:0]    err_o,
    output logic               busy_o,
    output logic [70:0]        m_data_o,
    output logic               m_out_en_o,
    input  logic               m_cs_i
);

    localparam int IDXW = $clog2(NREQ);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        LAUNCH,
        WAIT_LO,
        WAIT_HI,
        GAP
    } state_t;

    state_t          state_q;
    logic [IDXW-1:0] ptr_q;
    logic [IDXW-1:0] idx_q;
    logic [6:0]      len_q;
    logic [63:0]     payload_q;
    logic [15:0]     cnt_q;
    logic            cs_fell_q;
    logic [NREQ-1:0] ack_q;
    logic [NREQ-1:0] done_q;
    logic [NREQ-1:0] err_q;
    logic            busy_q;
    logic            m_out_en_q;
    logic [70:0]     m_data_q;

    logic            win_valid;
    logic [IDXW-1:0] win_idx;
    logic [IDXW-1:0] pos;
    logic [6:0]      win_len;
    logic [63:0]     win_data;
    logic            len_ok;
    logic [IDXW-1:0] ptr_d;

    // Round-robin pick: scan from the pointer upward with wrap. The loop runs
    // from the far end back toward the pointer so that the last hit written,
    // which is the one that sticks, is the requester closest to the pointer.
    // The winner's length and payload are then selected with constant slices.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        pos       = '0;
        win_len   = '0;
        win_data  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            pos = IDXW'((int'(ptr_q) + i) % NREQ);
            if (req_i[pos]) begin
                win_valid = 1'b1;
                win_idx   = pos;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IDXW'(i)) begin
                win_len  = req_len_i[7*i +: 7];
                win_data = req_data_i[64*i +: 64];
            end
        end
    end

    // The master only accepts even bit counts from 2 to 64.
    assign len_ok = (len_q >= 7'd2) && (len_q <= 7'd64) && !len_q[0];

    // After a transfer, the requester just served becomes the lowest priority.
    assign ptr_d = (idx_q == IDXW'(NREQ - 1)) ? '0 : idx_q + 1'b1;

    // Main sequencer. One counter is shared by the launch, the two CS waits
    // and the gap, because only one of them is ever active. A CS fall seen
    // while out_en is still high is remembered in cs_fell_q. The launch then
    // goes straight to waiting for the rise instead of waiting for a fall
    // that has already happened. The ack, done and err pulses default low
    // every cycle, so a one-cycle pulse only needs a single set.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            idx_q      <= '0;
            len_q      <= '0;
            payload_q  <= '0;
            cnt_q      <= '0;
            cs_fell_q  <= 1'b0;
            ack_q      <= '0;
            done_q     <= '0;
            err_q      <= '0;
            busy_q     <= 1'b0;
            m_out_en_q <= 1'b0;
            m_data_q   <= '0;
        end else begin
            ack_q  <= '0;
            done_q <= '0;
            err_q  <= '0;
            unique case (state_q)
                IDLE: begin
                    if (win_valid && m_cs_i) begin
                        idx_q          <= win_idx;
                        len_q          <= win_len;
                        payload_q      <= win_data;
                        ack_q[win_idx] <= 1'b1;
                        busy_q         <= 1'b1;
                        state_q        <= CHECK;
                    end
                end
                CHECK: begin
                    if (len_ok) begin
                        m_data_q   <= {len_q, payload_q};
                        m_out_en_q <= 1'b1;
                        cnt_q      <= '0;
                        cs_fell_q  <= 1'b0;
                        state_q    <= LAUNCH;
                    end else begin
                        err_q[idx_q] <= 1'b1;
                        ptr_q        <= ptr_d;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                LAUNCH: begin
                    if (!m_cs_i) begin
                        cs_fell_q <= 1'b1;
                    end
                    if (cnt_q == 16'(EN_CYC - 1)) begin
                        m_out_en_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= (cs_fell_q || !m_cs_i) ? WAIT_HI : WAIT_LO;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                WAIT_LO: begin
                    if (!m_cs_i) begin
                        cnt_q   <= '0;
                        state_q <= WAIT_HI;
                    end else if (cnt_q == 16'(TO_CYC - 1)) begin
                        err_q[idx_q] <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= GAP;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                WAIT_HI: begin
                    if (m_cs_i) begin
                        done_q[idx_q] <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= GAP;
                    end else if (cnt_q == 16'(TO_CYC - 1)) begin
                        err_q[idx_q] <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= GAP;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                GAP: begin
                    if (int'(cnt_q) + 1 >= GAP_CYC) begin
                        ptr_q    <= ptr_d;
                        m_data_q <= '0;
                        busy_q   <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack_o      = ack_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign busy_o     = busy_q;
    assign m_data_o   = m_data_q;
    assign m_out_en_o = m_out_en_q;

endmodule

// File: tb/tb_d2l_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_d2l_tx_scheduler
//
// Directed testbench for d2l_tx_scheduler. A small master model answers
// each out_en rise. It drops CS dropDelay clocks later and raises it
// holdDelay clocks after that. forceLow lets a test hold CS low from
// outside the model. Outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_d2l_tx_scheduler;

    localparam int NREQ    = 4;
    localparam int EN_CYC  = 2;
    localparam int GAP_CYC = 4;
    localparam int TO_CYC  = 1024;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic [NREQ-1:0]     req;
    logic [7*NREQ-1:0]   reqLen;
    logic [64*NREQ-1:0]  reqData;
    logic [NREQ-1:0]     ack;
    logic [NREQ-1:0]     done;
    logic [NREQ-1:0]     err;
    logic                busy;
    logic [70:0]         mData;
    logic                mOutEn;
    logic                mCs;

    logic                modelCs;
    logic                forceLow;
    logic                modelOn;
    logic                prevEn;
    int                  dropDelay;
    int                  holdDelay;
    int                  mPhase;
    int                  mCnt;

    int                  checks = 0;
    int                  errors = 0;

    d2l_tx_scheduler #(
        .NREQ    (NREQ),
        .EN_CYC  (EN_CYC),
        .GAP_CYC (GAP_CYC),
        .TO_CYC  (TO_CYC)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .req_i      (req),
        .req_len_i  (reqLen),
        .req_data_i (reqData),
        .ack_o      (ack),
        .done_o     (done),
        .err_o      (err),
        .busy_o     (busy),
        .m_data_o   (mData),
        .m_out_en_o (mOutEn),
        .m_cs_i     (mCs)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // CS seen by the DUT: the master model, unless a test forces it low.
    assign mCs = forceLow ? 1'b0 : modelCs;

    // Master model. A rising out_en is first seen one edge after it rises,
    // so the counter starts at 2 on that edge. CS then falls on the
    // dropDelay-th edge after the rise and rises holdDelay edges later.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            modelCs <= 1'b1;
            mPhase  <= 0;
            mCnt    <= 0;
            prevEn  <= 1'b0;
        end else begin
            prevEn <= mOutEn;
            if (!modelOn) begin
                modelCs <= 1'b1;
                mPhase  <= 0;
            end else begin
                case (mPhase)
                    0: if (mOutEn && !prevEn) begin
                        mCnt   <= 2;
                        mPhase <= 1;
                    end
                    1: if (mCnt >= dropDelay) begin
                        modelCs <= 1'b0;
                        mCnt    <= 1;
                        mPhase  <= 2;
                    end else begin
                        mCnt <= mCnt + 1;
                    end
                    2: if (mCnt >= holdDelay) begin
                        modelCs <= 1'b1;
                        mPhase  <= 0;
                    end else begin
                        mCnt <= mCnt + 1;
                    end
                    default: mPhase <= 0;
                endcase
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic setReq(input int i, input logic [6:0] len, input logic [63:0] data);
        reqLen[7*i +: 7]   = len;
        reqData[64*i +: 64] = data;
    endtask

    task automatic pulseReset();
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(1);
    endtask

    function automatic logic [63:0] rrPayload(input int i);
        return {48'hC0DE_1234_5678, 16'(i)};
    endfunction

    // Reset state: every output low and m_data cleared.
    task automatic test_reset();
        req       = '0;
        reqLen    = '0;
        reqData   = '0;
        forceLow  = 1'b0;
        modelOn   = 1'b0;
        dropDelay = 3;
        holdDelay = 40;
        rstn      = 1'b0;
        tick(3);
        checks++;
        if ({ack, done, err, busy, mOutEn} !== '0 || mData !== 71'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: ack=%b done=%b err=%b busy=%b en=%b data=%h, expected all zero",
                     ack, done, err, busy, mOutEn, mData);
        end
        rstn = 1'b1;
        tick(2);
        checks++;
        if (busy !== 1'b0 || ack !== '0) begin
            errors++;
            $display("[TB] FAIL reset_idle: busy=%b ack=%b, expected 0 and 0000", busy, ack);
        end
    endtask

    // Single request: ack, two cycles of out_en, captured data word,
    // exactly one done, then busy drops after the gap.
    task automatic test_single();
        int doneAt;
        int doneCnt;
        int errCnt;
        int busyFallAt;
        pulseReset();
        modelOn   = 1'b1;
        dropDelay = 3;
        holdDelay = 40;
        setReq(0, 7'd8, 64'h5A);
        req = 4'b0001;
        tick(1);
        checks++;
        if (ack !== 4'b0001 || busy !== 1'b1 || mOutEn !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_ack: ack=%b busy=%b en=%b, expected 0001 1 0", ack, busy, mOutEn);
        end
        req = '0;
        tick(1);
        checks++;
        if (mOutEn !== 1'b1 || mData !== {7'd8, 56'd0, 8'h5A} || ack !== '0) begin
            errors++;
            $display("[TB] FAIL single_launch: en=%b data=%h ack=%b, expected 1 %h 0000",
                     mOutEn, mData, ack, {7'd8, 56'd0, 8'h5A});
        end
        tick(1);
        checks++;
        if (mOutEn !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_en_2nd: got %b, expected 1", mOutEn);
        end
        tick(1);
        checks++;
        if (mOutEn !== 1'b0 || mData !== {7'd8, 56'd0, 8'h5A}) begin
            errors++;
            $display("[TB] FAIL single_en_off: en=%b data=%h, expected 0 and held data", mOutEn, mData);
        end
        doneAt     = -1;
        doneCnt    = 0;
        errCnt     = 0;
        busyFallAt = -1;
        for (int k = 5; k <= 70; k++) begin
            tick(1);
            if (done !== '0) begin
                doneCnt++;
                if (doneAt < 0 && done === 4'b0001) doneAt = k;
            end
            if (err !== '0) errCnt++;
            if (doneAt >= 0 && busyFallAt < 0 && busy === 1'b0) busyFallAt = k;
        end
        checks++;
        if (doneAt != 46 || doneCnt != 1 || errCnt != 0) begin
            errors++;
            $display("[TB] FAIL single_done: at=%0d count=%0d errs=%0d, expected at=46 count=1 errs=0",
                     doneAt, doneCnt, errCnt);
        end
        checks++;
        if (busyFallAt != 46 + GAP_CYC || mData !== 71'd0) begin
            errors++;
            $display("[TB] FAIL single_gap: busy fell at %0d data=%h, expected %0d and zero",
                     busyFallAt, mData, 46 + GAP_CYC);
        end
    endtask

    // All four requesting together: grants 0,1,2,3,0, each done before the
    // next ack, correct data on every launch, and the gap respected.
    task automatic test_round_robin();
        int   order[5];
        int   nAck;
        int   lastIdx;
        int   lastRise;
        int   idx;
        logic pendDone;
        logic prevCs;
        logic prevOut;
        pulseReset();
        modelOn   = 1'b1;
        dropDelay = 3;
        holdDelay = 10;
        for (int i = 0; i < NREQ; i++) setReq(i, 7'd16, rrPayload(i));
        req      = 4'b1111;
        nAck     = 0;
        lastIdx  = 0;
        lastRise = -1000;
        pendDone = 1'b0;
        prevCs   = 1'b1;
        prevOut  = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            tick(1);
            if (ack !== '0) begin
                idx = -1;
                for (int j = 0; j < NREQ; j++) if (ack[j] === 1'b1) idx = j;
                checks++;
                if ($countones(ack) != 1 || pendDone) begin
                    errors++;
                    $display("[TB] FAIL rr_ack_order: ack=%b pendingDone=%b, expected one-hot and previous done seen",
                             ack, pendDone);
                end
                if (nAck < 5) order[nAck] = idx;
                nAck++;
                lastIdx  = idx;
                pendDone = 1'b1;
                if (nAck == 5) req = '0;
            end
            if (done !== '0) begin
                checks++;
                if (done !== (4'b0001 << lastIdx)) begin
                    errors++;
                    $display("[TB] FAIL rr_done_idx: got %b, expected %b", done, 4'b0001 << lastIdx);
                end
                pendDone = 1'b0;
            end
            if (mCs === 1'b1 && prevCs === 1'b0) lastRise = k;
            if (mOutEn === 1'b1 && prevOut === 1'b0) begin
                checks++;
                if (mData !== {7'd16, rrPayload(lastIdx)}) begin
                    errors++;
                    $display("[TB] FAIL rr_data: got %h, expected %h", mData, {7'd16, rrPayload(lastIdx)});
                end
                if (nAck > 1) begin
                    checks++;
                    if (k - lastRise < GAP_CYC + 2) begin
                        errors++;
                        $display("[TB] FAIL rr_spacing: got %0d clk, expected at least %0d", k - lastRise, GAP_CYC + 2);
                    end
                end
            end
            prevCs  = mCs;
            prevOut = mOutEn;
        end
        checks++;
        if (nAck != 5) begin
            errors++;
            $display("[TB] FAIL rr_count: got %0d grants, expected 5", nAck);
        end else begin
            for (int g = 0; g < 5; g++) begin
                checks++;
                if (order[g] != g % NREQ) begin
                    errors++;
                    $display("[TB] FAIL rr_grant%0d: got %0d, expected %0d", g, order[g], g % NREQ);
                end
            end
        end
        checks++;
        if (pendDone || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rr_end: pendingDone=%b busy=%b, expected 0 0", pendDone, busy);
        end
    endtask

    // Bad lengths 7, 0 and 66 are rejected without a launch. The pointer
    // moves past requester 1, so 2 then beats 0.
    task automatic test_bad_len();
        logic [6:0] badLen;
        pulseReset();
        modelOn = 1'b1;
        for (int t = 0; t < 3; t++) begin
            badLen = (t == 0) ? 7'd7 : ((t == 1) ? 7'd0 : 7'd66);
            setReq(1, badLen, 64'hDEAD_BEEF_0000_0000 | 64'(t));
            req = 4'b0010;
            tick(1);
            checks++;
            if (ack !== 4'b0010) begin
                errors++;
                $display("[TB] FAIL badlen_ack len=%0d: got %b, expected 0010", badLen, ack);
            end
            req = '0;
            tick(1);
            checks++;
            if (err !== 4'b0010 || done !== '0 || mOutEn !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL badlen_err len=%0d: err=%b done=%b en=%b busy=%b, expected 0010 0000 0 0",
                         badLen, err, done, mOutEn, busy);
            end
            tick(1);
            checks++;
            if (err !== '0 || mOutEn !== 1'b0) begin
                errors++;
                $display("[TB] FAIL badlen_pulse len=%0d: err=%b en=%b, expected 0000 0", badLen, err, mOutEn);
            end
        end
        setReq(0, 7'd3, 64'h0);
        setReq(2, 7'd5, 64'h0);
        req = 4'b0101;
        tick(1);
        checks++;
        if (ack !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL badlen_ptr: got %b, expected 0100", ack);
        end
        req = 4'b0001;
        tick(1);
        checks++;
        if (err !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL badlen_err2: got %b, expected 0100", err);
        end
        tick(1);
        checks++;
        if (ack !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL badlen_next: got %b, expected 0001", ack);
        end
        req = '0;
        tick(2);
    endtask

    // Timeouts: CS never falls (err in WAIT_LO), then CS falls during the
    // launch and sticks low (err in WAIT_HI). Neither case gives a done.
    task automatic test_timeout();
        int errAt;
        int errCnt;
        int doneCnt;
        int busyFallAt;
        modelOn  = 1'b0;
        forceLow = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            setReq(2 + pass, 7'd8, 64'h1234 + 64'(pass));
            req = (pass == 0) ? 4'b0100 : 4'b1000;
            tick(1);
            checks++;
            if (ack !== req) begin
                errors++;
                $display("[TB] FAIL timeout%0d_ack: got %b, expected %b", pass, ack, req);
            end
            req = '0;
            tick(2);
            if (pass == 1) forceLow = 1'b1;
            tick(1);
            errAt      = -1;
            errCnt     = 0;
            doneCnt    = 0;
            busyFallAt = -1;
            for (int k = 5; k <= 4 + TO_CYC + GAP_CYC + 8; k++) begin
                tick(1);
                if (err !== '0) begin
                    errCnt++;
                    if (errAt < 0 && err === (4'b0100 << pass)) errAt = k;
                end
                if (done !== '0) doneCnt++;
                if (errAt >= 0 && busyFallAt < 0 && busy === 1'b0) busyFallAt = k;
            end
            checks++;
            if (errAt != 4 + TO_CYC || errCnt != 1 || doneCnt != 0) begin
                errors++;
                $display("[TB] FAIL timeout%0d_err: at=%0d count=%0d dones=%0d, expected at=%0d count=1 dones=0",
                         pass, errAt, errCnt, doneCnt, 4 + TO_CYC);
            end
            checks++;
            if (busyFallAt != 4 + TO_CYC + GAP_CYC) begin
                errors++;
                $display("[TB] FAIL timeout%0d_busy: fell at %0d, expected %0d",
                         pass, busyFallAt, 4 + TO_CYC + GAP_CYC);
            end
            forceLow = 1'b0;
            tick(2);
        end
    endtask

    // Reset during WAIT_HI clears every output at once. After release the
    // held requests are arbitrated again from pointer 0.
    task automatic test_reset_mid();
        int doneCnt;
        int errCnt;
        setReq(1, 7'd3, 64'h0);
        req = 4'b0010;
        tick(1);
        req = '0;
        tick(2);
        modelOn   = 1'b1;
        dropDelay = 3;
        holdDelay = 40;
        setReq(2, 7'd64, 64'hFEDC_BA98_7654_3210);
        setReq(0, 7'd5, 64'h0);
        req = 4'b0100;
        tick(1);
        checks++;
        if (ack !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL rstmid_ack: got %b, expected 0100", ack);
        end
        tick(14);
        checks++;
        if (mData !== {7'd64, 64'hFEDC_BA98_7654_3210} || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid_pre: data=%h busy=%b, expected %h 1",
                     mData, busy, {7'd64, 64'hFEDC_BA98_7654_3210});
        end
        req  = 4'b0101;
        rstn = 1'b0;
        #1;
        checks++;
        if ({ack, done, err, busy, mOutEn} !== '0 || mData !== 71'd0) begin
            errors++;
            $display("[TB] FAIL rstmid_async: ack=%b done=%b err=%b busy=%b en=%b data=%h, expected all zero",
                     ack, done, err, busy, mOutEn, mData);
        end
        doneCnt = 0;
        errCnt  = 0;
        for (int k = 0; k < 2; k++) begin
            tick(1);
            if (done !== '0) doneCnt++;
            if (err !== '0) errCnt++;
        end
        rstn = 1'b1;
        tick(1);
        checks++;
        if (ack !== 4'b0001 || doneCnt != 0 || errCnt != 0) begin
            errors++;
            $display("[TB] FAIL rstmid_rearb: ack=%b dones=%0d errs=%0d, expected 0001 0 0", ack, doneCnt, errCnt);
        end
        req = 4'b0100;
        tick(2);
        checks++;
        if (ack !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL rstmid_regrant: got %b, expected 0100", ack);
        end
        req     = '0;
        doneCnt = 0;
        for (int k = 0; k < 70; k++) begin
            tick(1);
            if (done === 4'b0100) doneCnt++;
            if (err !== '0) errCnt++;
        end
        checks++;
        if (doneCnt != 1 || errCnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_done: dones=%0d errs=%0d busy=%b, expected 1 0 0", doneCnt, errCnt, busy);
        end
    endtask

    // A request arriving while CS is held low from outside waits for CS high.
    task automatic test_cs_busy();
        int early;
        int doneCnt;
        modelOn  = 1'b1;
        forceLow = 1'b1;
        setReq(1, 7'd8, 64'h0123_4567_89AB_CDEF);
        req   = 4'b0010;
        early = 0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            if (ack !== '0 || busy !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("[TB] FAIL csbusy_wait: %0d cycles with ack or busy, expected 0", early);
        end
        forceLow = 1'b0;
        tick(1);
        checks++;
        if (ack !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL csbusy_ack: got %b, expected 0010", ack);
        end
        req = '0;
        tick(1);
        checks++;
        if (mOutEn !== 1'b1 || mData !== {7'd8, 64'h0123_4567_89AB_CDEF}) begin
            errors++;
            $display("[TB] FAIL csbusy_launch: en=%b data=%h, expected 1 %h",
                     mOutEn, mData, {7'd8, 64'h0123_4567_89AB_CDEF});
        end
        doneCnt = 0;
        for (int k = 0; k < 70; k++) begin
            tick(1);
            if (done === 4'b0010) doneCnt++;
        end
        checks++;
        if (doneCnt != 1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL csbusy_done: dones=%0d busy=%b, expected 1 0", doneCnt, busy);
        end
    endtask

    // Scenario sequence.
    initial begin
        $display("[TB] starting d2l_tx_scheduler bench");
        test_reset();
        test_single();
        test_round_robin();
        test_bad_len();
        test_timeout();
        test_reset_mid();
        test_cs_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
